// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: widths, opcodes, handshake states
// and NZP helpers.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 8;
    localparam int REG_WIDTH    = 16;
    localparam int PC_WIDTH     = 16;

    // ALU group
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 8'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 8'h06;
    // Memory group
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h11;
    // Unconditional control flow
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 8'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 8'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR  = 8'h22;
    // Conditional branches: 8'b11000_nzp, low three bits are the condition mask
    localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 8'hC1;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 8'hC2;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 8'hC3;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 8'hC4;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 8'hC5;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 8'hC6;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 8'hC7;

    // Condition-code bit positions
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // Data-memory handshake states
    typedef enum logic {
        MS_IDLE   = 1'b0,
        MS_ACCESS = 1'b1
    } ms_state_e;

    function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_AND) ||
               (op == OP_ANDI) || (op == OP_MOV) || (op == OP_MOVI);
    endfunction

    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

    function automatic logic is_cond_branch(input logic [OPCODE_WIDTH-1:0] op);
        return op[OPCODE_WIDTH-1:3] == 5'b11000;
    endfunction

    // Condition codes derived from a value being written back
    function automatic logic [2:0] nzp_of(input logic [REG_WIDTH-1:0] v);
        logic [2:0] c;
        c        = 3'b000;
        c[NZP_N] = v[REG_WIDTH-1];
        c[NZP_Z] = (v == '0);
        c[NZP_P] = !v[REG_WIDTH-1] && (v != '0);
        return c;
    endfunction

endpackage

// File: rtl/memory_stage_mem_handshake_fsm.sv
// Data-memory req/ack handshake: owns the IDLE/ACCESS state, the request
// registers and (with MEMSTAGE_TIMEOUT_EN defined) the ack watchdog.
// State updates on the falling clock edge.
import memory_stage_pkg::*;

module mem_handshake_fsm #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [REG_WIDTH-1:0]      wdata_i,
    input  logic                      ack_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [REG_WIDTH-1:0]      mem_wdata_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      mem_error_o
);

    ms_state_e                 state_q, state_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]      wdata_q, wdata_d;

`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Next state: issue on start, retire on ack, optionally give up on timeout
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_o  = 1'b0;
`ifdef MEMSTAGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            MS_IDLE: begin
                if (start_i) begin
                    state_d = MS_ACCESS;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
`ifdef MEMSTAGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            MS_ACCESS: begin
                if (ack_i) begin
                    state_d = MS_IDLE;
                    req_d   = 1'b0;
                    done_o  = 1'b1;
                end
`ifdef MEMSTAGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = MS_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // State and request registers; reset aborts any access in flight
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MS_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEMSTAGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEMSTAGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q == MS_ACCESS);
`ifdef MEMSTAGE_TIMEOUT_EN
    assign mem_error_o = err_q;
`else
    assign mem_error_o = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: accepts execute results, issues LDW/STW through the
// handshake FSM, resolves branches against its NZP register and registers the
// writeback outputs. Optional ack watchdog: define MEMSTAGE_TIMEOUT_EN.
import memory_stage_pkg::*;

module memory_stage #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      I_CLOCK,
    input  logic                      I_RESET,
    input  logic                      I_LOCK,
    input  logic [OPCODE_WIDTH-1:0]   I_Opcode,
    input  logic [REG_WIDTH-1:0]      I_ALUOut,
    input  logic [3:0]                I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]      I_DestValue,
    input  logic                      I_FetchStall,
    input  logic                      I_DepStall,
    output logic                      O_MemReq,
    output logic                      O_MemWe,
    output logic [MEM_ADDR_WIDTH-1:0] O_MemAddr,
    output logic [REG_WIDTH-1:0]      O_MemWData,
    input  logic                      I_MemAck,
    input  logic [REG_WIDTH-1:0]      I_MemRData,
    output logic                      O_MemStall,
    output logic                      O_LOCK,
    output logic                      O_Valid,
    output logic [OPCODE_WIDTH-1:0]   O_Opcode,
    output logic [3:0]                O_DestRegIdx,
    output logic [REG_WIDTH-1:0]      O_WBValue,
    output logic                      O_WBEnable,
    output logic                      O_BranchTaken,
    output logic [PC_WIDTH-1:0]       O_BranchPC,
    output logic                      O_MemError
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memory_stage: TIMEOUT_CYCLES must be at least 1");
    end

    logic busy, mem_done, accept, issue;

    logic                    lock_q;
    logic                    valid_q, valid_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [3:0]              dest_q, dest_d;
    logic [REG_WIDTH-1:0]    wbval_q, wbval_d;
    logic                    wben_q, wben_d;
    logic                    br_q, br_d;
    logic [PC_WIDTH-1:0]     brpc_q, brpc_d;
    logic [2:0]              nzp_q, nzp_d;
    logic [OPCODE_WIDTH-1:0] acc_op_q, acc_op_d;
    logic [3:0]              acc_dest_q, acc_dest_d;

    assign accept = !busy && I_LOCK && !I_FetchStall && !I_DepStall;
    assign issue  = accept && is_mem_op(I_Opcode);

    mem_handshake_fsm #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs (
        .clk         (I_CLOCK),
        .rst         (I_RESET),
        .start_i     (issue),
        .we_i        (I_Opcode == OP_STW),
        .addr_i      (I_ALUOut[MEM_ADDR_WIDTH-1:0]),
        .wdata_i     (I_DestValue),
        .ack_i       (I_MemAck),
        .mem_req_o   (O_MemReq),
        .mem_we_o    (O_MemWe),
        .mem_addr_o  (O_MemAddr),
        .mem_wdata_o (O_MemWData),
        .busy_o      (busy),
        .done_o      (mem_done),
        .mem_error_o (O_MemError)
    );

    // Retirement: memory completion, ALU writeback, branch resolution or bubble
    always_comb begin
        valid_d    = 1'b0;
        wben_d     = 1'b0;
        br_d       = 1'b0;
        op_d       = op_q;
        dest_d     = dest_q;
        wbval_d    = wbval_q;
        brpc_d     = brpc_q;
        nzp_d      = nzp_q;
        acc_op_d   = acc_op_q;
        acc_dest_d = acc_dest_q;
        if (mem_done) begin
            valid_d = 1'b1;
            op_d    = acc_op_q;
            dest_d  = acc_dest_q;
            if (!O_MemWe) begin
                wbval_d = I_MemRData;
                wben_d  = 1'b1;
                nzp_d   = nzp_of(I_MemRData);
            end
        end else if (accept) begin
            if (is_mem_op(I_Opcode)) begin
                // Issue edge is a bubble; remember what retires on ack
                acc_op_d   = I_Opcode;
                acc_dest_d = I_DestRegIdx;
            end else begin
                valid_d = 1'b1;
                op_d    = I_Opcode;
                dest_d  = I_DestRegIdx;
                if (is_alu_op(I_Opcode)) begin
                    wbval_d = I_ALUOut;
                    wben_d  = 1'b1;
                    nzp_d   = nzp_of(I_ALUOut);
                end else if (is_cond_branch(I_Opcode)) begin
                    if ((I_Opcode[2:0] & nzp_q) != 3'b000) begin
                        br_d   = 1'b1;
                        brpc_d = PC_WIDTH'(I_DestValue);
                    end
                end else if (I_Opcode == OP_JMP) begin
                    br_d   = 1'b1;
                    brpc_d = PC_WIDTH'(I_DestValue);
                end else if ((I_Opcode == OP_JSR) || (I_Opcode == OP_JSRR)) begin
                    br_d    = 1'b1;
                    brpc_d  = PC_WIDTH'(I_DestValue);
                    wbval_d = I_ALUOut;
                    wben_d  = 1'b1;
                end
            end
        end
    end

    // Writeback, redirect and condition-code registers
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lock_q     <= 1'b0;
            valid_q    <= 1'b0;
            op_q       <= '0;
            dest_q     <= '0;
            wbval_q    <= '0;
            wben_q     <= 1'b0;
            br_q       <= 1'b0;
            brpc_q     <= '0;
            nzp_q      <= 3'b010;
            acc_op_q   <= '0;
            acc_dest_q <= '0;
        end else begin
            lock_q     <= I_LOCK;
            valid_q    <= valid_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            wbval_q    <= wbval_d;
            wben_q     <= wben_d;
            br_q       <= br_d;
            brpc_q     <= brpc_d;
            nzp_q      <= nzp_d;
            acc_op_q   <= acc_op_d;
            acc_dest_q <= acc_dest_d;
        end
    end

    assign O_MemStall    = O_MemReq;
    assign O_LOCK        = lock_q;
    assign O_Valid       = valid_q;
    assign O_Opcode      = op_q;
    assign O_DestRegIdx  = dest_q;
    assign O_WBValue     = wbval_q;
    assign O_WBEnable    = wben_q;
    assign O_BranchTaken = br_q;
    assign O_BranchPC    = brpc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage. Outputs are sampled 1 time unit after the
// active (falling) clock edge. Build with MEMSTAGE_TIMEOUT_EN to exercise the
// watchdog with TIMEOUT_CYCLES=4.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic                    I_CLOCK = 1'b1;
    logic                    I_RESET = 1'b1;
    logic                    I_LOCK = 1'b0;
    logic [OPCODE_WIDTH-1:0] I_Opcode = '0;
    logic [REG_WIDTH-1:0]    I_ALUOut = '0;
    logic [3:0]              I_DestRegIdx = '0;
    logic [REG_WIDTH-1:0]    I_DestValue = '0;
    logic                    I_FetchStall = 1'b0;
    logic                    I_DepStall = 1'b0;
    logic                    I_MemAck = 1'b0;
    logic [REG_WIDTH-1:0]    I_MemRData = '0;
    logic                    O_MemReq, O_MemWe, O_MemStall, O_LOCK, O_Valid;
    logic [15:0]             O_MemAddr;
    logic [REG_WIDTH-1:0]    O_MemWData, O_WBValue;
    logic [OPCODE_WIDTH-1:0] O_Opcode;
    logic [3:0]              O_DestRegIdx;
    logic                    O_WBEnable, O_BranchTaken, O_MemError;
    logic [PC_WIDTH-1:0]     O_BranchPC;

    int n_tests = 0;
    int n_fail  = 0;

    memory_stage #(
        .MEM_ADDR_WIDTH (16),
`ifdef MEMSTAGE_TIMEOUT_EN
        .TIMEOUT_CYCLES (4)
`else
        .TIMEOUT_CYCLES (15)
`endif
    ) dut (
        .I_CLOCK       (I_CLOCK),
        .I_RESET       (I_RESET),
        .I_LOCK        (I_LOCK),
        .I_Opcode      (I_Opcode),
        .I_ALUOut      (I_ALUOut),
        .I_DestRegIdx  (I_DestRegIdx),
        .I_DestValue   (I_DestValue),
        .I_FetchStall  (I_FetchStall),
        .I_DepStall    (I_DepStall),
        .O_MemReq      (O_MemReq),
        .O_MemWe       (O_MemWe),
        .O_MemAddr     (O_MemAddr),
        .O_MemWData    (O_MemWData),
        .I_MemAck      (I_MemAck),
        .I_MemRData    (I_MemRData),
        .O_MemStall    (O_MemStall),
        .O_LOCK        (O_LOCK),
        .O_Valid       (O_Valid),
        .O_Opcode      (O_Opcode),
        .O_DestRegIdx  (O_DestRegIdx),
        .O_WBValue     (O_WBValue),
        .O_WBEnable    (O_WBEnable),
        .O_BranchTaken (O_BranchTaken),
        .O_BranchPC    (O_BranchPC),
        .O_MemError    (O_MemError)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [OPCODE_WIDTH-1:0] op, input logic [15:0] alu,
                           input logic [3:0] idx, input logic [15:0] dval);
        I_LOCK       = 1'b1;
        I_FetchStall = 1'b0;
        I_DepStall   = 1'b0;
        I_Opcode     = op;
        I_ALUOut     = alu;
        I_DestRegIdx = idx;
        I_DestValue  = dval;
    endtask

    task automatic no_instr();
        I_LOCK   = 1'b0;
        I_Opcode = '0;
    endtask

    // Advance past one active edge and settle
    task automatic tick();
        @(negedge I_CLOCK);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_req", O_MemReq, 0);
        check("rst_stall", O_MemStall, 0);
        check("rst_valid", O_Valid, 0);
        check("rst_wbval", O_WBValue, 0);
        check("rst_br", O_BranchTaken, 0);
        check("rst_lock", O_LOCK, 0);
        check("rst_err", O_MemError, 0);
        I_RESET = 1'b0;

        // ADDI producing a negative value
        present(OP_ADDI, 16'hFFFE, 4'd3, 16'h0000); tick();
        check("addi_valid", O_Valid, 1);
        check("addi_wben", O_WBEnable, 1);
        check("addi_wbval", O_WBValue, 16'hFFFE);
        check("addi_dest", O_DestRegIdx, 3);
        check("addi_op", O_Opcode, OP_ADDI);
        check("addi_lock", O_LOCK, 1);

        // BRN taken against N, then a single-edge pulse
        present(OP_BRN, 16'h0000, 4'd0, 16'h0040); tick();
        check("brn_taken", O_BranchTaken, 1);
        check("brn_pc", O_BranchPC, 16'h0040);
        check("brn_wben", O_WBEnable, 0);
        check("brn_valid", O_Valid, 1);
        no_instr(); tick();
        check("brn_pulse_end", O_BranchTaken, 0);
        check("bubble_valid", O_Valid, 0);
        check("bubble_lock", O_LOCK, 0);
        present(OP_BRZ, 16'h0000, 4'd0, 16'h0080); tick();
        check("brz_not_taken", O_BranchTaken, 0);
        check("brz_pc_held", O_BranchPC, 16'h0040);
        present(OP_BRP, 16'h0000, 4'd0, 16'h0090); tick();
        check("brp_not_taken", O_BranchTaken, 0);

        // LDW acked on the third edge after issue; ADD presented meanwhile is ignored
        present(OP_LDW, 16'h0010, 4'd5, 16'h0000); tick();
        check("ldw_req", O_MemReq, 1);
        check("ldw_stall", O_MemStall, 1);
        check("ldw_we", O_MemWe, 0);
        check("ldw_addr", O_MemAddr, 16'h0010);
        check("ldw_issue_bubble", O_Valid, 0);
        present(OP_ADD, 16'h7777, 4'd1, 16'h0000); tick();
        check("ldw_req_e1", O_MemReq, 1);
        check("ldw_addr_e1", O_MemAddr, 16'h0010);
        check("ldw_bubble_e1", O_Valid, 0);
        tick();
        check("ldw_req_e2", O_MemReq, 1);
        check("ldw_stall_e2", O_MemStall, 1);
        check("ldw_addr_e2", O_MemAddr, 16'h0010);
        I_MemAck = 1'b1; I_MemRData = 16'h1234; tick();
        check("ldw_req_done", O_MemReq, 0);
        check("ldw_stall_done", O_MemStall, 0);
        check("ldw_valid", O_Valid, 1);
        check("ldw_wben", O_WBEnable, 1);
        check("ldw_wbval", O_WBValue, 16'h1234);
        check("ldw_dest", O_DestRegIdx, 5);
        check("ldw_op", O_Opcode, OP_LDW);
        I_MemAck = 1'b0; I_MemRData = 16'h0000;
        present(OP_BRP, 16'h0000, 4'd0, 16'h0100); tick();
        check("ldw_nzp_p_taken", O_BranchTaken, 1);
        check("ldw_nzp_p_pc", O_BranchPC, 16'h0100);
        present(OP_BRNZ, 16'h0000, 4'd0, 16'h0110); tick();
        check("ldw_nzp_nz_not", O_BranchTaken, 0);

        // STW acked on the first edge
        present(OP_STW, 16'h0020, 4'd2, 16'hBEEF); tick();
        check("stw_req", O_MemReq, 1);
        check("stw_we", O_MemWe, 1);
        check("stw_addr", O_MemAddr, 16'h0020);
        check("stw_wdata", O_MemWData, 16'hBEEF);
        no_instr(); I_MemAck = 1'b1; tick();
        check("stw_req_done", O_MemReq, 0);
        check("stw_valid", O_Valid, 1);
        check("stw_wben", O_WBEnable, 0);
        check("stw_op", O_Opcode, OP_STW);
        check("stw_wbval_held", O_WBValue, 16'h1234);

        // Ack while idle is ignored
        tick();
        check("idle_ack_req", O_MemReq, 0);
        check("idle_ack_valid", O_Valid, 0);
        I_MemAck = 1'b0;

        // Upstream stalls turn an ADD into a bubble
        present(OP_ADD, 16'h0000, 4'd4, 16'h0000); I_DepStall = 1'b1; tick();
        check("dep_valid", O_Valid, 0);
        check("dep_wben", O_WBEnable, 0);
        check("dep_wbval", O_WBValue, 16'h1234);
        present(OP_ADD, 16'h0000, 4'd4, 16'h0000); I_FetchStall = 1'b1; tick();
        check("fetch_valid", O_Valid, 0);
        check("fetch_dest", O_DestRegIdx, 2);
        present(OP_BRP, 16'h0000, 4'd0, 16'h0120); tick();
        check("stall_nzp_kept", O_BranchTaken, 1);

        // JSR writes link but leaves NZP; JMP redirects without writeback
        present(OP_JSR, 16'h8000, 4'd7, 16'h0200); tick();
        check("jsr_taken", O_BranchTaken, 1);
        check("jsr_pc", O_BranchPC, 16'h0200);
        check("jsr_wben", O_WBEnable, 1);
        check("jsr_wbval", O_WBValue, 16'h8000);
        check("jsr_dest", O_DestRegIdx, 7);
        present(OP_BRN, 16'h0000, 4'd0, 16'h0130); tick();
        check("jsr_nzp_kept", O_BranchTaken, 0);
        present(OP_JMP, 16'h0000, 4'd0, 16'h0300); tick();
        check("jmp_taken", O_BranchTaken, 1);
        check("jmp_pc", O_BranchPC, 16'h0300);
        check("jmp_wben", O_WBEnable, 0);

        // ADD producing zero, then BRZ
        present(OP_ADD, 16'h0000, 4'd6, 16'h0000); tick();
        check("add_zero_wben", O_WBEnable, 1);
        check("add_zero_wbval", O_WBValue, 0);
        present(OP_BRZ, 16'h0000, 4'd0, 16'h0140); tick();
        check("brz_taken", O_BranchTaken, 1);

        // LDW that is never acknowledged
        present(OP_LDW, 16'h0030, 4'd8, 16'h0000); tick();
        check("noack_req", O_MemReq, 1);
        no_instr();
`ifdef MEMSTAGE_TIMEOUT_EN
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("to_req_held", O_MemReq, 1);
            check("to_err_low", O_MemError, 0);
        end
        tick();
        check("to_req_drop", O_MemReq, 0);
        check("to_stall_drop", O_MemStall, 0);
        check("to_err_set", O_MemError, 1);
        check("to_valid", O_Valid, 0);
        check("to_wben", O_WBEnable, 0);
        tick(); tick();
        check("to_err_sticky", O_MemError, 1);
        present(OP_BRZ, 16'h0000, 4'd0, 16'h0150); tick();
        check("to_nzp_kept", O_BranchTaken, 1);
        check("to_err_sticky2", O_MemError, 1);
        present(OP_LDW, 16'h0040, 4'd8, 16'h0000); tick();
        check("to_reissue_req", O_MemReq, 1);
        check("to_reissue_addr", O_MemAddr, 16'h0040);
        no_instr();
`else
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("wait_req_held", O_MemReq, 1);
            check("wait_no_err", O_MemError, 0);
        end
`endif

        // Asynchronous reset in the middle of an access
        #2;
        I_RESET = 1'b1;
        #1;
        check("mid_rst_req", O_MemReq, 0);
        check("mid_rst_stall", O_MemStall, 0);
        check("mid_rst_err", O_MemError, 0);
        check("mid_rst_valid", O_Valid, 0);
        #1;
        I_RESET = 1'b0;
        tick();
        check("post_rst_req", O_MemReq, 0);
        // NZP returns to Z after reset
        present(OP_BRZ, 16'h0000, 4'd0, 16'h0160); tick();
        check("post_rst_brz", O_BranchTaken, 1);
        check("post_rst_pc", O_BranchPC, 16'h0160);
        no_instr(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
